// File: rtl/cdiv_pkg.sv
// Shared definitions for the complex divider: default widths, quotient
// width derivation and the control state encoding.
package cdiv_pkg;

    localparam int W_DEF    = 32;
    localparam int FRAC_DEF = 16;

    // Quotient width: two integer guard bits cover the sqrt(2) growth of |a|/|b|.
    function automatic int qw_of(input int w, input int frac);
        return w + 2 + frac;
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/complex_divider_if.sv
// Operand/result handshake bundle for the complex divider.
interface complex_divider_if
    import cdiv_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int FRAC = FRAC_DEF
);
    localparam int QW = qw_of(W, FRAC);

    logic                 in_valid;
    logic                 in_ready;
    logic signed [W-1:0]  ar;
    logic signed [W-1:0]  ai;
    logic signed [W-1:0]  br;
    logic signed [W-1:0]  bi;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [QW-1:0] qr;
    logic signed [QW-1:0] qi;
    logic                 dz;

    modport master (
        output in_valid, ar, ai, br, bi, out_ready,
        input  in_ready, out_valid, qr, qi, dz
    );

    modport slave (
        input  in_valid, ar, ai, br, bi, out_ready,
        output in_ready, out_valid, qr, qi, dz
    );

endinterface

// File: rtl/udiv_step_seq.sv
// Unsigned radix-2 restoring divider, one quotient bit per step.
// The upper dividend bits seed the remainder (they are known to be below
// the divisor because the quotient fits QW bits); the lower QW bits are
// shifted out MSB-first while quotient bits shift in at the bottom.
module udiv_step_seq #(
    parameter int QW = 50,
    parameter int DW = 80,
    parameter int VW = 64
) (
    input  logic          clk,
    input  logic          load,
    input  logic          step,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic [QW-1:0] quotient
);
    logic [VW-1:0] rem_q, rem_d;
    logic [QW-1:0] sh_q, sh_d;
    logic [VW:0]   trial;
    logic          keep;

    // Next remainder/shift register: load seeds, step performs one restore cycle.
    always_comb begin
        rem_d = rem_q;
        sh_d  = sh_q;
        trial = {rem_q, sh_q[QW-1]};
        keep  = (trial >= {1'b0, divisor});
        if (load) begin
            rem_d = VW'(dividend[DW-1:QW]);
            sh_d  = dividend[QW-1:0];
        end else if (step) begin
            rem_d = keep ? (trial[VW-1:0] - divisor) : trial[VW-1:0];
            sh_d  = {sh_q[QW-2:0], keep};
        end
    end

    // Datapath registers, no reset: contents are always reloaded before use.
    always_ff @(posedge clk) begin
        rem_q <= rem_d;
        sh_q  <= sh_d;
    end

    assign quotient = sh_q;

endmodule

// File: rtl/complex_divider.sv
// Sequential fixed-point complex divider q = a / b.
// MUL forms conj(b)*a and |b|^2, DIV runs two restoring dividers on the
// magnitudes in lock-step, DONE applies signs and holds the result.
module complex_divider
    import cdiv_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int FRAC = FRAC_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    complex_divider_if.slave   bus
);
    localparam int QW = qw_of(W, FRAC);
    localparam int DW = 2 * W + FRAC;
    localparam int VW = 2 * W;
    localparam int CW = $clog2(QW);

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q;
    logic                 out_valid_q;
    logic                 dz_q;
    logic signed [QW-1:0] qr_q, qi_q;

    logic signed [W-1:0]  ar_q, ai_q, br_q, bi_q;
    logic [VW-1:0]        den_q;
    logic                 sr_q, si_q, zero_q;

    logic [2*W:0]         nr, ni;
    logic [VW-1:0]        den;
    logic [QW-1:0]        quo_r, quo_i;
    logic                 accept, out_fire, load, step;

    function automatic logic [2*W:0] sx(input logic signed [W-1:0] v);
        return {{(W+1){v[W-1]}}, v};
    endfunction

    // Magnitude of a 2W+1-bit two's complement value; always fits 2W bits here.
    function automatic logic [VW-1:0] mag(input logic [2*W:0] v);
        return v[2*W] ? (~v[VW-1:0] + VW'(1)) : v[VW-1:0];
    endfunction

    // Re-applies the numerator sign; magnitude truncation gives round-toward-zero.
    function automatic logic signed [QW-1:0] apply_sign(input logic neg, input logic [QW-1:0] m);
        return neg ? $signed(~m + QW'(1)) : $signed(m);
    endfunction

    assign accept   = bus.in_valid && (state_q == IDLE);
    assign out_fire = out_valid_q && bus.out_ready;
    assign load     = (state_q == MUL) && (den != '0);
    assign step     = (state_q == DIV);

    // Conjugate-product numerators and squared-magnitude denominator.
    always_comb begin
        nr  = sx(ar_q) * sx(br_q) + sx(ai_q) * sx(bi_q);
        ni  = sx(ai_q) * sx(br_q) - sx(ar_q) * sx(bi_q);
        den = VW'(sx(br_q) * sx(br_q) + sx(bi_q) * sx(bi_q));
    end

    // Next-state logic for the IDLE/MUL/DIV/DONE sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.in_valid) state_d = MUL;
            MUL:  state_d = (den == '0) ? DONE : DIV;
            DIV:  if (cnt_q == CW'(QW - 1)) state_d = DONE;
            DONE: if (out_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control state, step counter and the held result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            dz_q        <= 1'b0;
            qr_q        <= '0;
            qi_q        <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == MUL)
                cnt_q <= '0;
            else if (step)
                cnt_q <= cnt_q + CW'(1);
            if (accept) begin
                dz_q <= 1'b0;
            end else if ((state_q == DONE) && !out_valid_q) begin
                out_valid_q <= 1'b1;
                dz_q        <= zero_q;
                qr_q        <= zero_q ? '0 : apply_sign(sr_q, quo_r);
                qi_q        <= zero_q ? '0 : apply_sign(si_q, qi_sel(quo_i));
            end else if (out_fire) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    function automatic logic [QW-1:0] qi_sel(input logic [QW-1:0] q);
        return q;
    endfunction

    // Operand capture and per-operation sign/denominator latches (data only).
    always_ff @(posedge clk) begin
        if (accept) begin
            ar_q <= bus.ar;
            ai_q <= bus.ai;
            br_q <= bus.br;
            bi_q <= bus.bi;
        end
        if (state_q == MUL) begin
            den_q  <= den;
            sr_q   <= nr[2*W];
            si_q   <= ni[2*W];
            zero_q <= (den == '0);
        end
    end

    udiv_step_seq #(.QW(QW), .DW(DW), .VW(VW)) u_div_re (
        .clk      (clk),
        .load     (load),
        .step     (step),
        .dividend ({mag(nr), {FRAC{1'b0}}}),
        .divisor  (den_q),
        .quotient (quo_r)
    );

    udiv_step_seq #(.QW(QW), .DW(DW), .VW(VW)) u_div_im (
        .clk      (clk),
        .load     (load),
        .step     (step),
        .dividend ({mag(ni), {FRAC{1'b0}}}),
        .divisor  (den_q),
        .quotient (quo_i)
    );

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.qr        = qr_q;
    assign bus.qi        = qi_q;
    assign bus.dz        = dz_q;

endmodule
